svm_vector_serializer: RTL and testbench

- Feeds the SVM accumulator.
- Accepts one complete HOG block descriptor (VECTOR_LENGTH elements) per valid/ready handshake.
- Emits the elements as a serial value_de/value stream, one element per cycle, with no gap between consecutive vectors.
- Presents each vector's chained partial sum on init_value/init_value_de so the accumulator adds it to that vector's dot product.

---
 rtl/svm_vector_serializer_pkg.sv | 17 +
 rtl/svm_vector_serializer_if.sv | 38 +++
 rtl/svm_vector_serializer_slot.sv | 47 ++++
 rtl/svm_vector_serializer.sv | 171 +++++++++++++++++
 tb/tb_svm_vector_serializer.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/svm_vector_serializer_pkg.sv
// -----------------------------------------------------------------------------
// svm_pkg
//   Shared definitions for the SVM vector serializer slice: default vector
//   geometry, partial-sum width and the serializer FSM state type.
// -----------------------------------------------------------------------------
package svm_pkg;

   localparam int SVM_VECTOR_LENGTH = 36;  // elements per HOG block descriptor
   localparam int SVM_VECTOR_WIDTH  = 12;  // unsigned element width
   localparam int SVM_ACC_WIDTH     = 44;  // signed partial-sum width

   typedef enum logic {
      IDLE,
      STREAM
   } svm_ser_state_t;

endpackage

// File: rtl/svm_vector_serializer_if.sv
// -----------------------------------------------------------------------------
// svm_vector_serializer_if
//   Bundles the descriptor handshake (in_*) and the serial element stream
//   (value*, init_value*, busy) of the SVM vector serializer.
//   Modports:
//     slave  - the serializer: takes in_valid/in_vector/in_init_value,
//              drives in_ready and the stream outputs.
//     master - the producer / stream consumer side (the mirror image).
// -----------------------------------------------------------------------------
interface svm_vector_serializer_if
   import svm_pkg::*;
#(
   parameter int VECTOR_LENGTH = SVM_VECTOR_LENGTH,
   parameter int VECTOR_WIDTH  = SVM_VECTOR_WIDTH,
   parameter int ACC_WIDTH     = SVM_ACC_WIDTH
) ();

   logic                                    in_valid;
   logic                                    in_ready;
   logic [VECTOR_LENGTH*VECTOR_WIDTH-1:0]   in_vector;
   logic signed [ACC_WIDTH-1:0]             in_init_value;
   logic                                    value_de;
   logic [VECTOR_WIDTH-1:0]                 value;
   logic                                    init_value_de;
   logic signed [ACC_WIDTH-1:0]             init_value;
   logic                                    busy;

   modport slave (
      input  in_valid, in_vector, in_init_value,
      output in_ready, value_de, value, init_value_de, init_value, busy
   );

   modport master (
      output in_valid, in_vector, in_init_value,
      input  in_ready, value_de, value, init_value_de, init_value, busy
   );

endinterface

// File: rtl/svm_vector_serializer_slot.sv
// -----------------------------------------------------------------------------
// svm_vector_slot
//   One holding register for a descriptor and its partial sum, with a valid
//   flag. load has priority over clear, so a slot can be emptied and refilled
//   on the same edge.
//   Ports:
//     clk, reset_n       clock, asynchronous active-low reset
//     load               capture d_vector/d_init, set valid
//     clear              drop valid (ignored when load is high)
//     d_vector, d_init   data to capture
//     q_vector, q_init   held data
//     valid              slot holds a vector
// -----------------------------------------------------------------------------
module svm_vector_slot #(
   parameter int DATA_WIDTH = 432,
   parameter int ACC_WIDTH  = 44
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        load,
   input  logic                        clear,
   input  logic [DATA_WIDTH-1:0]       d_vector,
   input  logic signed [ACC_WIDTH-1:0] d_init,
   output logic [DATA_WIDTH-1:0]       q_vector,
   output logic signed [ACC_WIDTH-1:0] q_init,
   output logic                        valid
);

   // NOTE: non-blocking assignments in every clocked block, so each flop
   // samples the pre-edge value of the others regardless of process order.
   // NOTE: the payload is reset together with valid; a vector dropped by a
   // mid-stream reset leaves nothing behind that could leak out later.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid    <= 1'b0;
         q_vector <= '0;
         q_init   <= '0;
      end else if (load) begin
         valid    <= 1'b1;
         q_vector <= d_vector;
         q_init   <= d_init;
      end else if (clear) begin
         valid    <= 1'b0;
      end
   end

endmodule

// File: rtl/svm_vector_serializer.sv
// -----------------------------------------------------------------------------
// svm_vector_serializer
//   Accepts one HOG block descriptor per handshake and streams its elements,
//   element 0 first, one per cycle on value/value_de with no gap between
//   back-to-back vectors. The vector's partial sum appears on init_value with
//   a one-cycle init_value_de pulse on the final beat.
//   Two slots: active (streaming) and pending (next in line).
//   Ports:
//     clk, reset_n   clock, asynchronous active-low reset
//     pause          only with SVM_SERIALIZER_PAUSE_EN: high at an edge
//                    suppresses the beat of the following cycle
//     bus (slave)    in_valid/in_ready/in_vector/in_init_value handshake,
//                    value_de/value/init_value_de/init_value/busy stream
//   Build option: define SVM_SERIALIZER_PAUSE_EN to add the pause port.
//   All outputs come straight from flops.
// -----------------------------------------------------------------------------
module svm_vector_serializer
   import svm_pkg::*;
#(
   parameter int VECTOR_LENGTH = SVM_VECTOR_LENGTH,
   parameter int VECTOR_WIDTH  = SVM_VECTOR_WIDTH,
   parameter int ACC_WIDTH     = SVM_ACC_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset_n,
`ifdef SVM_SERIALIZER_PAUSE_EN
   input  logic                  pause,
`endif
   svm_vector_serializer_if.slave bus
);

   localparam int                VEC_BITS = VECTOR_LENGTH * VECTOR_WIDTH;
   localparam int                CNT_W    = $clog2(VECTOR_LENGTH);
   localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(VECTOR_LENGTH - 1);

   logic hold;
`ifdef SVM_SERIALIZER_PAUSE_EN
   assign hold = pause;
`else
   assign hold = 1'b0;
`endif

   svm_ser_state_t               state_q, state_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;
   logic                         in_ready_q, ready_d;
   logic                         value_de_q, de_d;
   logic [VECTOR_WIDTH-1:0]      value_q, elem_d;
   logic                         init_de_q, last_d;
   logic signed [ACC_WIDTH-1:0]  init_q, init_d;
   logic                         busy_q, busy_d;

   logic                         act_load, act_clear, act_valid;
   logic                         pend_load, pend_clear, pend_valid;
   logic [VEC_BITS-1:0]          act_vec, pend_vec, act_d_vec, nxt_vec;
   logic signed [ACC_WIDTH-1:0]  act_init, pend_init, act_d_init, nxt_init;
   logic                         act_valid_nxt, pend_valid_nxt;
   logic                         accept, final_now;

   assign accept    = bus.in_valid & in_ready_q;
   // The beat on the output right now is the last element of the active vector.
   assign final_now = value_de_q & (cnt_q == LAST_IDX);

   // Active refills from pending when one is waiting, otherwise from the input.
   assign act_d_vec  = pend_valid ? pend_vec  : bus.in_vector;
   assign act_d_init = pend_valid ? pend_init : bus.in_init_value;

   svm_vector_slot #(.DATA_WIDTH(VEC_BITS), .ACC_WIDTH(ACC_WIDTH)) u_active (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (act_load),
      .clear    (act_clear),
      .d_vector (act_d_vec),
      .d_init   (act_d_init),
      .q_vector (act_vec),
      .q_init   (act_init),
      .valid    (act_valid)
   );

   svm_vector_slot #(.DATA_WIDTH(VEC_BITS), .ACC_WIDTH(ACC_WIDTH)) u_pending (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (pend_load),
      .clear    (pend_clear),
      .d_vector (bus.in_vector),
      .d_init   (bus.in_init_value),
      .q_vector (pend_vec),
      .q_init   (pend_init),
      .valid    (pend_valid)
   );

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = STREAM;
         STREAM:  if (final_now && !pend_valid && !accept) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Slot control and the values the output registers take at the next edge.
   // The output stage looks one edge ahead: it selects from whatever the
   // active slot will hold after this edge, so a freshly accepted vector shows
   // element 0 in the very next cycle.
   // NOTE: every signal gets a default before any branch, so no path leaves a
   // variable unassigned and no latch is inferred.
   always_comb begin
      act_load   = (state_q == IDLE && accept) ||
                   (final_now && (pend_valid || accept));
      act_clear  = final_now && !pend_valid && !accept;
      pend_load  = accept && state_q == STREAM && (!final_now || pend_valid);
      pend_clear = final_now && pend_valid;

      act_valid_nxt  = act_load  || (act_valid  && !act_clear);
      pend_valid_nxt = pend_load || (pend_valid && !pend_clear);

      cnt_d = cnt_q;
      if (final_now)       cnt_d = '0;
      else if (value_de_q) cnt_d = cnt_q + CNT_W'(1);

      nxt_vec  = act_load ? act_d_vec  : act_vec;
      nxt_init = act_load ? act_d_init : act_init;

      de_d   = (state_d == STREAM) && !hold;
      elem_d = '0;
      for (int i = 0; i < VECTOR_LENGTH; i++) begin
         if (de_d && cnt_d == CNT_W'(i)) elem_d = nxt_vec[i*VECTOR_WIDTH +: VECTOR_WIDTH];
      end
      last_d = de_d && (cnt_d == LAST_IDX);
      init_d = last_d ? nxt_init : '0;

      // Ready also during a final beat: pending drains into active at that
      // edge, so a descriptor offered there can take its place.
      ready_d = !pend_valid_nxt || last_d;
      busy_d  = act_valid_nxt || pend_valid_nxt;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q      <= '0;
         in_ready_q <= 1'b0;
         value_de_q <= 1'b0;
         value_q    <= '0;
         init_de_q  <= 1'b0;
         init_q     <= '0;
         busy_q     <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         in_ready_q <= ready_d;
         value_de_q <= de_d;
         value_q    <= elem_d;
         init_de_q  <= last_d;
         init_q     <= init_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.in_ready      = in_ready_q;
   assign bus.value_de      = value_de_q;
   assign bus.value         = value_q;
   assign bus.init_value_de = init_de_q;
   assign bus.init_value    = init_q;
   assign bus.busy          = busy_q;

endmodule

// File: tb/tb_svm_vector_serializer.sv
// -----------------------------------------------------------------------------
// tb_svm_vector_serializer
//   Self-checking bench for svm_vector_serializer. A queue model of the held
//   vectors predicts every output each cycle; directed scenarios add literal
//   expectations on beat order, timing and partial sums. Define
//   SVM_SERIALIZER_PAUSE_EN to also exercise the pause build.
// -----------------------------------------------------------------------------
module tb_svm_vector_serializer;
   import svm_pkg::*;

   localparam int L = SVM_VECTOR_LENGTH;
   localparam int W = SVM_VECTOR_WIDTH;
   localparam int A = SVM_ACC_WIDTH;

   typedef logic [L*W-1:0]       vec_t;
   typedef logic signed [A-1:0]  acc_t;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   logic pause   = 1'b0;

   always #5 clk = ~clk;

   svm_vector_serializer_if #(.VECTOR_LENGTH(L), .VECTOR_WIDTH(W), .ACC_WIDTH(A)) bus ();

   svm_vector_serializer #(.VECTOR_LENGTH(L), .VECTOR_WIDTH(W), .ACC_WIDTH(A)) dut (
      .clk     (clk),
      .reset_n (reset_n),
`ifdef SVM_SERIALIZER_PAUSE_EN
      .pause   (pause),
`endif
      .bus     (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [W-1:0] elem(input vec_t v, input int i);
      return v[i*W +: W];
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // ---------------- behavioural model ----------------
   // Queue of held vectors (front = streaming); pos = next element of the front.
   vec_t            mq_vec[$];
   acc_t            mq_init[$];
   int              pos       = 0;
   logic            exp_ready = 1'b0;
   logic            exp_de    = 1'b0;
   logic [W-1:0]    exp_val   = '0;
   logic            exp_ide   = 1'b0;
   acc_t            exp_init  = '0;
   logic            exp_busy  = 1'b0;
   vec_t            m_front;

   initial forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
         mq_vec.delete();
         mq_init.delete();
         pos = 0;
         exp_ready = 1'b0; exp_de = 1'b0; exp_val = '0;
         exp_ide = 1'b0; exp_init = '0; exp_busy = 1'b0;
      end else begin
         logic took;
         took = bus.in_valid && exp_ready;
         if (exp_de) begin
            pos++;
            if (pos == L) begin
               void'(mq_vec.pop_front());
               void'(mq_init.pop_front());
               pos = 0;
            end
         end
         if (took) begin
            mq_vec.push_back(bus.in_vector);
            mq_init.push_back(bus.in_init_value);
         end
         exp_de = (mq_vec.size() > 0) && !pause;
         if (exp_de) begin
            m_front = mq_vec[0];
            exp_val = elem(m_front, pos);
         end else begin
            exp_val = '0;
         end
         exp_ide   = exp_de && (pos == L - 1);
         exp_init  = exp_ide ? mq_init[0] : '0;
         exp_busy  = mq_vec.size() > 0;
         // Room for one more, or the front finishes at the coming edge.
         exp_ready = (mq_vec.size() < 2) || exp_ide;
      end
   end

   // ---------------- compare + monitor ----------------
   int   beat_val[$];
   int   beat_cyc[$];
   acc_t init_log[$];
   int   init_cyc[$];

   initial forever begin
      @(negedge clk);
      check("in_ready",      {63'd0, bus.in_ready},      {63'd0, exp_ready});
      check("value_de",      {63'd0, bus.value_de},      {63'd0, exp_de});
      check("value",         64'(bus.value),             64'(exp_val));
      check("init_value_de", {63'd0, bus.init_value_de}, {63'd0, exp_ide});
      check("init_value",    64'(bus.init_value),        64'(exp_init));
      check("busy",          {63'd0, bus.busy},          {63'd0, exp_busy});
      // Spec cycle numbering: the period after edge n is cycle n+1.
      if (bus.value_de) begin
         beat_val.push_back(int'(bus.value));
         beat_cyc.push_back(cyc + 1);
      end
      if (bus.init_value_de) begin
         init_log.push_back(bus.init_value);
         init_cyc.push_back(cyc + 1);
      end
   end

   // ---------------- driver helpers ----------------
   task automatic clear_logs();
      beat_val.delete(); beat_cyc.delete(); init_log.delete(); init_cyc.delete();
   endtask

   // Called at a negedge; returns at the negedge after acceptance with the
   // index of the accepting edge. in_valid is left high.
   task automatic send(input vec_t v, input acc_t init, output int edge_idx);
      bus.in_valid      = 1'b1;
      bus.in_vector     = v;
      bus.in_init_value = init;
      edge_idx = -1;
      for (int t = 0; t < 400; t++) begin
         if (exp_ready) begin
            @(negedge clk);
            edge_idx = cyc;
            return;
         end
         @(negedge clk);
      end
      n_checks++;
      $display("FAIL send_timeout: descriptor not accepted within 400 cycles");
   endtask

   task automatic wait_idle();
      for (int t = 0; t < 1000; t++) begin
         if (!exp_busy && !bus.busy) return;
         @(negedge clk);
      end
      n_checks++;
      $display("FAIL idle_timeout: busy still high after 1000 cycles");
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // ---------------- scenarios ----------------
   vec_t    va, vb, vc;
   acc_t    ia;
   int      k, kb, m;
   longint  s_dut, s_ref;

   initial begin
      bus.in_valid      = 1'b0;
      bus.in_vector     = '0;
      bus.in_init_value = '0;

      #1;
      check("rst_in_ready",      {63'd0, bus.in_ready},      64'd0);
      check("rst_value_de",      {63'd0, bus.value_de},      64'd0);
      check("rst_value",         64'(bus.value),             64'd0);
      check("rst_init_value_de", {63'd0, bus.init_value_de}, 64'd0);
      check("rst_init_value",    64'(bus.init_value),        64'd0);
      check("rst_busy",          {63'd0, bus.busy},          64'd0);

      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("ready_after_reset", {63'd0, bus.in_ready}, 64'd1);

      // --- 1: single vector, element i = i+1, init 100 ---
      clear_logs();
      for (int i = 0; i < L; i++) va[i*W +: W] = W'(i + 1);
      send(va, acc_t'(44'h0_0000_0064), k);
      bus.in_valid = 1'b0;
      m = -1;
      for (int t = 0; t < 100; t++) begin
         if (!bus.busy) begin m = cyc; break; end
         @(negedge clk);
      end
      check("t1_beats", 64'(beat_val.size()), 64'(L));
      for (int i = 0; i < L && i < beat_val.size(); i++) check("t1_value", 64'(beat_val[i]), 64'(i + 1));
      if (beat_cyc.size() > 0) check("t1_first_beat_cycle", 64'(beat_cyc[0]), 64'(k + 1));
      check("t1_init_pulses", 64'(init_log.size()), 64'd1);
      if (init_log.size() > 0) begin
         check("t1_init_value", 64'(init_log[0]), 64'd100);
         check("t1_init_cycle", 64'(init_cyc[0]), 64'(k + L));
      end
      check("t1_busy_drop_cycle", 64'(m + 1), 64'(k + L + 1));
      wait_idle();

      // --- 2: three vectors back-to-back, in_valid held high ---
      clear_logs();
      for (int i = 0; i < L; i++) begin
         va[i*W +: W] = W'($urandom);
         vb[i*W +: W] = W'($urandom);
         vc[i*W +: W] = W'($urandom);
      end
      send(va, acc_t'(-5), k);
      send(vb, acc_t'(0),  k);
      send(vc, acc_t'(7),  k);
      bus.in_valid = 1'b0;
      wait_idle();
      check("t2_beats", 64'(beat_val.size()), 64'(3 * L));
      if (beat_cyc.size() == 3 * L) check("t2_contiguous", 64'(beat_cyc[3*L-1] - beat_cyc[0]), 64'(3 * L - 1));
      if (beat_val.size() == 3 * L) begin
         check("t2_b_elem0", 64'(beat_val[L]),       64'(elem(vb, 0)));
         check("t2_c_last",  64'(beat_val[3*L-1]),   64'(elem(vc, L - 1)));
      end
      check("t2_init_pulses", 64'(init_log.size()), 64'd3);
      if (init_log.size() == 3 && beat_cyc.size() > 0) begin
         check("t2_init_a", 64'(init_log[0]), 64'(acc_t'(-5)));
         check("t2_init_b", 64'(init_log[1]), 64'd0);
         check("t2_init_c", 64'(init_log[2]), 64'd7);
         for (int j = 0; j < 3; j++) check("t2_init_cycle", 64'(init_cyc[j]), 64'(beat_cyc[0] + L * (j + 1) - 1));
      end

      // --- 3: handshake exactly on the final-beat edge, pending empty ---
      clear_logs();
      for (int i = 0; i < L; i++) begin
         va[i*W +: W] = W'(i + 1);
         vb[i*W +: W] = W'(12'h800 + i);
      end
      send(va, acc_t'(1), k);
      bus.in_valid = 1'b0;
      repeat (L - 1) @(negedge clk);
      send(vb, acc_t'(2), kb);
      bus.in_valid = 1'b0;
      wait_idle();
      check("t3_accept_edge", 64'(kb), 64'(k + L));
      check("t3_beats", 64'(beat_val.size()), 64'(2 * L));
      if (beat_val.size() == 2 * L) begin
         check("t3_no_gap",   64'(beat_cyc[L] - beat_cyc[L-1]), 64'd1);
         check("t3_b_elem0",  64'(beat_val[L]), 64'h800);
      end

      // --- 4: reset during beat 17 ---
      clear_logs();
      for (int i = 0; i < L; i++) va[i*W +: W] = W'(12'h200 + i);
      send(va, acc_t'(3), k);
      bus.in_valid = 1'b0;
      repeat (16) @(negedge clk);
      check("t4_beat17_before_reset", 64'(bus.value), 64'h210);
      #2 reset_n = 1'b0;
      #1;
      check("t4_rst_value_de",      {63'd0, bus.value_de},      64'd0);
      check("t4_rst_value",         64'(bus.value),             64'd0);
      check("t4_rst_init_value_de", {63'd0, bus.init_value_de}, 64'd0);
      check("t4_rst_busy",          {63'd0, bus.busy},          64'd0);
      check("t4_rst_in_ready",      {63'd0, bus.in_ready},      64'd0);
      repeat (2) @(negedge clk);
      clear_logs();
      reset_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < L; i++) vb[i*W +: W] = W'(12'h400 + i);
      send(vb, acc_t'(4), k);
      bus.in_valid = 1'b0;
      wait_idle();
      check("t4_fresh_beats", 64'(beat_val.size()), 64'(L));
      for (int i = 0; i < L && i < beat_val.size(); i++) check("t4_fresh_value", 64'(beat_val[i]), 64'(12'h400 + i));

      // --- 5: boundary values and end-to-end weighted accumulation ---
      clear_logs();
      for (int i = 0; i < L; i++) va[i*W +: W] = (i % 2 == 0) ? W'(12'hFFF) : W'(0);
      ia = acc_t'(44'h800_0000_0000);
      send(va, ia, k);
      bus.in_valid = 1'b0;
      wait_idle();
      check("t5_beats", 64'(beat_val.size()), 64'(L));
      for (int i = 0; i < L && i < beat_val.size(); i++)
         check("t5_value", 64'(beat_val[i]), (i % 2 == 0) ? 64'hFFF : 64'h0);
      if (init_log.size() == 1) begin
         check("t5_init_most_negative", 64'(init_log[0]), 64'(ia));
         s_dut = longint'(init_log[0]);
         for (int i = 0; i < beat_val.size(); i++) s_dut += longint'(i + 1) * longint'(beat_val[i]);
         // Weights w_i = i+1 over 0xFFF at even i: 4095 * (1+3+...+35) = 4095*324.
         s_ref = -longint'(64'h0000_0800_0000_0000) + longint'(4095) * longint'(324);
         check("t5_acc_sum", 64'(s_dut), 64'(s_ref));
      end else begin
         check("t5_init_pulses", 64'(init_log.size()), 64'd1);
      end

`ifdef SVM_SERIALIZER_PAUSE_EN
      // --- 6: pause for elements 10-12 ---
      clear_logs();
      for (int i = 0; i < L; i++) va[i*W +: W] = W'(i + 1);
      send(va, acc_t'(9), k);
      bus.in_valid = 1'b0;
      repeat (9) @(negedge clk);
      pause = 1'b1;
      repeat (3) @(negedge clk);
      pause = 1'b0;
      wait_idle();
      check("t6_beats", 64'(beat_val.size()), 64'(L));
      if (beat_val.size() == L) begin
         check("t6_resume_elem", 64'(beat_val[10]), 64'd11);
         check("t6_gap", 64'(beat_cyc[10] - beat_cyc[9]), 64'd4);
      end
      if (init_cyc.size() == 1) check("t6_init_delay", 64'(init_cyc[0]), 64'(k + L + 3));
`endif

      // --- 7: random vectors with random idle gaps ---
      for (int n = 0; n < 30; n++) begin
         for (int i = 0; i < L; i++) va[i*W +: W] = W'($urandom);
         ia = acc_t'({$urandom, $urandom});
         send(va, ia, k);
         if ($urandom_range(0, 2) == 0) begin
            bus.in_valid = 1'b0;
            repeat ($urandom_range(1, 40)) @(negedge clk);
         end
      end
      bus.in_valid = 1'b0;
      wait_idle();
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
